axis_trans_arbiter: RTL and testbench

// - Round-robin arbiter that shares one AxisTrans unit (registered s_in - f_in, 1-cycle latency) among NREQ requesters.
// - Each result is tagged with its requester id and signed-overflow flag, then queued in a 2-entry output FIFO.
// - Credit scheme: no issue unless a FIFO slot is guaranteed, so results are never dropped under backpressure.
// - Sits between the symmetry-folding front end (many coordinate lanes) and the downstream consumer.

---
 rtl/axis_trans_arbiter_pkg.sv | 16 +
 rtl/axis_trans.sv | 33 +++
 rtl/axis_trans_arbiter_rr_grant.sv | 39 +++
 rtl/axis_trans_arbiter.sv | 124 ++++++++++++
 tb/tb_axis_trans_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_trans_arbiter_pkg.sv
// Shared constants for the AxisTrans round-robin arbiter.
// FIFO entry layout is {data[W], id[IDW], ovf}, MSB first.
package axis_trans_arbiter_pkg;

    localparam int M_DEF      = 4;
    localparam int N_DEF      = 8;
    localparam int NREQ_DEF   = 4;
    localparam int W_DEF      = M_DEF + N_DEF;
    localparam int IDW_DEF    = $clog2(NREQ_DEF);
    localparam int FIFO_DEPTH = 2;

    function automatic int ent_w(input int w, input int idw);
        return w + idw + 1;
    endfunction

endpackage

// File: rtl/axis_trans.sv
// AxisTrans unit: registered s_in - f_in, one cycle latency.
// Both function types yield the same wrapped difference.
module axis_trans #(
    parameter int M         = 4,
    parameter int N         = 8,
    parameter int FUNC_TYPE = 0,
    localparam int W        = M + N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] f_in,
    input  logic [W-1:0] s_in,
    output logic [W-1:0] res_o
);

    logic [W-1:0] diff;
    logic [W-1:0] res_q;

    if (FUNC_TYPE == 1) begin : g_f1
        assign diff = s_in - f_in;
    end else begin : g_f0
        assign diff = s_in + (~f_in) + W'(1);
    end

    // Result register
    always_ff @(posedge clk) begin
        if (rst) res_q <= '0;
        else     res_q <= diff;
    end

    assign res_o = res_q;

endmodule

// File: rtl/axis_trans_arbiter_rr_grant.sv
// Round-robin grant: rotate requests by ptr, pick lowest, unrotate.
// Produces a one-hot grant plus the granted index.
module axis_trans_arbiter_rr_grant #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW-1:0]    first;
    logic [IDW:0]      sum;
    logic              found;

    // Rotate, priority-encode from lane ptr, then map back
    always_comb begin
        dbl   = {req_i, req_i};
        rot   = NREQ'(dbl >> ptr_i);
        first = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                first = IDW'(i);
            end
        end
        sum = {1'b0, first} + {1'b0, ptr_i};
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        idx_o = sum[IDW-1:0];
        any_o = found;
        gnt_o = found ? (NREQ'(1) << sum) : '0;
    end

endmodule

// File: rtl/axis_trans_arbiter.sv
// Shares one AxisTrans among NREQ requesters; results are tagged
// and queued in a 2-entry FIFO, issue is gated by free FIFO credit.
module axis_trans_arbiter
    import axis_trans_arbiter_pkg::*;
#(
    parameter int M         = M_DEF,
    parameter int N         = N_DEF,
    parameter int NREQ      = NREQ_DEF,
    parameter int FUNC_TYPE = 0,
    localparam int W        = M + N,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ*W-1:0] req_f,
    input  logic [NREQ*W-1:0] req_s,
    output logic [NREQ-1:0] req_ready,
    output logic            res_valid,
    output logic [W-1:0]    res_data,
    output logic [IDW-1:0]  res_id,
    output logic            res_ovf,
    input  logic            res_ready,
    output logic            busy
);

    localparam int EW = ent_w(W, IDW);

    logic [IDW-1:0] rr_q;
    logic           inflight_q;
    logic [IDW-1:0] tag_id_q;
    logic           tag_ovf_q;
    logic [1:0]     count_q, count_d;
    logic           rd_q, wr_q;
    logic [EW-1:0]  mem_q [FIFO_DEPTH];

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gidx;
    logic            gany;
    logic            can_issue, issue, push, pop;
    logic [W-1:0]    f_sel, s_sel, d_sel, axis_res;
    logic            ovf_sel;
    logic [EW-1:0]   head;

    axis_trans_arbiter_rr_grant #(.NREQ(NREQ)) u_rr (
        .req_i (req_valid),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (gany)
    );

    assign can_issue = ({1'b0, count_q} + {2'b0, inflight_q}) < 3'(FIFO_DEPTH);
    assign issue     = can_issue & gany;
    assign req_ready = can_issue ? gnt : '0;

    assign f_sel   = issue ? req_f[gidx*W +: W] : '0;
    assign s_sel   = issue ? req_s[gidx*W +: W] : '0;
    assign d_sel   = s_sel - f_sel;
    assign ovf_sel = (s_sel[W-1] != f_sel[W-1]) & (d_sel[W-1] != s_sel[W-1]);

    axis_trans #(.M(M), .N(N), .FUNC_TYPE(FUNC_TYPE)) u_axis (
        .clk   (clk),
        .rst   (rst),
        .f_in  (f_sel),
        .s_in  (s_sel),
        .res_o (axis_res)
    );

    // Tag pipe alongside AxisTrans, plus round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            inflight_q <= 1'b0;
            tag_id_q   <= '0;
            tag_ovf_q  <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                tag_id_q  <= gidx;
                tag_ovf_q <= ovf_sel;
                rr_q <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
            end
        end
    end

    assign push = inflight_q;
    assign pop  = res_valid & res_ready;

    // FIFO occupancy next state
    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 2'd1;
        else if (pop && !push) count_d = count_q - 2'd1;
    end

    // FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                mem_q[wr_q] <= {axis_res, tag_id_q, tag_ovf_q};
                wr_q        <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
        end
    end

    assign head      = mem_q[rd_q];
    assign res_valid = (count_q != 2'd0);
    assign res_data  = head[EW-1 -: W];
    assign res_id    = head[IDW:1];
    assign res_ovf   = head[0];
    assign busy      = inflight_q | res_valid;

    a_no_fifo_ovf: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count_q == 2'(FIFO_DEPTH)));

endmodule

// File: tb/tb_axis_trans_arbiter.sv
// Bench for axis_trans_arbiter: queue-based reference model checked
// every cycle, plus directed literal expectations.
module tb_axis_trans_arbiter;

    localparam int M    = 4;
    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int W    = M + N;
    localparam int IDW  = 2;
    localparam int MASK = (1 << W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_f;
    logic [NREQ*W-1:0] req_s;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic [W-1:0]      res_data;
    logic [IDW-1:0]    res_id;
    logic              res_ovf;
    logic              res_ready;
    logic              busy;

    axis_trans_arbiter #(.M(M), .N(N), .NREQ(NREQ), .FUNC_TYPE(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_f     (req_f),
        .req_s     (req_s),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int id;
        int ovf;
    } res_t;

    int   total = 0;
    int   bad   = 0;
    int   ops   = 0;
    bit   mon   = 0;
    res_t mfifo[$];
    res_t pend;
    bit   pend_v = 0;
    int   rr = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= (1 << (W-1))) ? v - (1 << W) : v;
    endfunction

    function automatic res_t model_op(input int lane, input int s, input int f);
        res_t r;
        int d;
        d = sx(s) - sx(f);
        r.data = d & MASK;
        r.id   = lane;
        r.ovf  = (d > (1 << (W-1)) - 1 || d < -(1 << (W-1))) ? 1 : 0;
        return r;
    endfunction

    // Reference model: checked and advanced once per cycle
    always @(negedge clk) begin
        #1;
        if (mon) begin
            int g;
            int exp_rdy;
            bit can;
            g = -1;
            can = (mfifo.size() + int'(pend_v)) < 2;
            if (can) begin
                for (int k = 0; k < NREQ; k++) begin
                    int l;
                    l = (rr + k) % NREQ;
                    if (g < 0 && req_valid[l]) g = l;
                end
            end
            exp_rdy = (g >= 0) ? (1 << g) : 0;
            chk("req_ready", int'(req_ready), exp_rdy);
            chk("res_valid", int'(res_valid), int'(mfifo.size() != 0));
            chk("busy", int'(busy), int'(pend_v || mfifo.size() != 0));
            if (mfifo.size() != 0) begin
                chk("res_data", int'(res_data), mfifo[0].data);
                chk("res_id", int'(res_id), mfifo[0].id);
                chk("res_ovf", int'(res_ovf), mfifo[0].ovf);
            end
            if (rst) begin
                mfifo.delete();
                pend_v = 0;
                rr = 0;
            end else begin
                if (mfifo.size() != 0 && res_ready) void'(mfifo.pop_front());
                if (pend_v) mfifo.push_back(pend);
                pend_v = (g >= 0);
                if (g >= 0) begin
                    pend = model_op(g, int'(req_s[g*W +: W]), int'(req_f[g*W +: W]));
                    rr = (g + 1) % NREQ;
                    ops++;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_op(input int lane, input int s, input int f,
                         input int ed, input int eo, input string nm);
        repeat (4) @(negedge clk);
        req_s[lane*W +: W] = W'(s);
        req_f[lane*W +: W] = W'(f);
        req_valid = NREQ'(1 << lane);
        #2;
        chk({nm, "_grant"}, int'(req_ready), 1 << lane);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #2;
        chk({nm, "_valid"}, int'(res_valid), 1);
        chk({nm, "_data"}, int'(res_data), ed);
        chk({nm, "_id"}, int'(res_id), lane);
        chk({nm, "_ovf"}, int'(res_ovf), eo);
    endtask

    function automatic int oh2i(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        int gl[$];
        int il[$];
        int cyc;
        rst = 1'b1;
        req_valid = '0;
        req_f = '0;
        req_s = '0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mon = 1;
        rst = 1'b0;
        #2;
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_res_ovf", int'(res_ovf), 0);
        chk("rst_busy", int'(busy), 0);

        do_op(2, 'h100, 'h080, 'h080, 0, "single");
        do_op(0, 'h7FF, 'h800, 'hFFF, 1, "ovf_pos");
        do_op(1, 'h800, 'h001, 'h7FF, 1, "ovf_neg");

        // Fairness
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_s[i*W +: W] = W'(16 * i + 3);
            req_f[i*W +: W] = W'(i);
        end
        req_valid = '1;
        res_ready = 1'b1;
        cyc = 0;
        while (gl.size() < 8 && cyc < 40) begin
            #2;
            if (req_ready != 0) gl.push_back(oh2i(req_ready));
            if (res_valid && res_ready) il.push_back(int'(res_id));
            if (gl.size() < 8) @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        req_valid = '0;
        repeat (8) begin
            #2;
            if (res_valid && res_ready) il.push_back(int'(res_id));
            @(negedge clk);
        end
        chk("fair_grants", gl.size(), 8);
        chk("fair_ids", il.size(), 8);
        foreach (gl[i]) chk("fair_grant_order", gl[i], i % NREQ);
        foreach (il[i]) chk("fair_id_order", il[i], i % NREQ);

        // Backpressure
        do_reset();
        req_valid = '1;
        res_ready = 1'b0;
        cyc = 0;
        repeat (10) begin
            #2;
            if (req_ready != 0) cyc++;
            @(negedge clk);
        end
        #2;
        chk("bp_accepted", cyc, 2);
        chk("bp_ready_low", int'(req_ready), 0);
        chk("bp_full_valid", int'(res_valid), 1);
        @(negedge clk);
        req_valid = '0;
        res_ready = 1'b1;
        il.delete();
        repeat (6) begin
            #2;
            if (res_valid && res_ready) il.push_back(int'(res_id));
            @(negedge clk);
        end
        chk("bp_drained", il.size(), 2);
        foreach (il[i]) chk("bp_drain_order", il[i], i);

        // Reset mid-stream with inflight=1, count=1
        do_reset();
        res_ready = 1'b0;
        req_valid = 4'b1000;
        @(negedge clk);
        req_valid = 4'b0010;
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'b1010;
        #2;
        chk("mid_busy_pre", int'(busy), 1);
        chk("mid_valid_pre", int'(res_valid), 1);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("mid_res_valid", int'(res_valid), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_grant", int'(req_ready), 4'b0010);

        // Random
        @(negedge clk);
        req_valid = '0;
        res_ready = 1'b1;
        do_reset();
        ops = 0;
        cyc = 0;
        while (ops < 10000 && cyc < 60000) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                int sel;
                sel = $urandom_range(0, 7);
                req_valid[i] = ($urandom_range(0, 3) != 0);
                if (sel == 0) begin
                    req_s[i*W +: W] = W'('h7FF);
                    req_f[i*W +: W] = W'($urandom);
                end else if (sel == 1) begin
                    req_s[i*W +: W] = W'('h800);
                    req_f[i*W +: W] = W'($urandom);
                end else begin
                    req_s[i*W +: W] = W'($urandom);
                    req_f[i*W +: W] = W'($urandom);
                end
            end
            res_ready = ($urandom_range(0, 4) != 0);
            cyc++;
        end
        chk("random_ops_done", int'(ops >= 10000), 1);
        @(negedge clk);
        req_valid = '0;
        res_ready = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        chk("final_busy", int'(busy), 0);
        mon = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
